// File: rtl/jt51_lfo_pm.sv
// jt51_lfo_pm
// Low-frequency oscillator for JT51. Once per 32-slot frame (marked by zero)
// it advances a rate accumulator, steps an 8-bit phase on accumulator carry,
// and produces a depth-scaled phase-modulation word (sign-magnitude) and an
// unsigned amplitude-modulation word. Both outputs change only at slot 1 and
// then hold for the rest of the frame.
//
// Build option: define JT51_LFO_NOISE_EN to include the 15-bit noise LFSR
// (w = 3 selects noise). Without it, w = 3 produces pm = 0 and am = 0.
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   rst_n     asynchronous active-low reset
//   cen       clock enable; nothing changes while low
//   zero      high for one cen cycle at slot 0 of each frame
//   lfrq[7:0] rate: [7:4] exponent, [3:0] mantissa
//   w[1:0]    waveform: 0 saw, 1 square, 2 triangle, 3 noise
//   amd[6:0]  AM depth
//   pmd[6:0]  PM depth
//   lfo_rst   synchronous LFO restart, acted on at cen & zero
//   pm[7:0]   bit 7 sign (1 = subtract), [6:0] magnitude
//   am[7:0]   unsigned AM attenuation
//   lfo_tick  one-cen pulse when the phase advances
module jt51_lfo_pm #(
  parameter logic [14:0] SEED = 15'h7FFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       zero,
  input  logic [7:0] lfrq,
  input  logic [1:0] w,
  input  logic [6:0] amd,
  input  logic [6:0] pmd,
  input  logic       lfo_rst,
  output logic [7:0] pm,
  output logic [7:0] am,
  output logic       lfo_tick
);

  function automatic logic [7:0] f_am_scale(input logic [7:0] raw, input logic [6:0] depth);
    logic [14:0] prod;
    prod = 15'(raw) * 15'(depth);
    return prod[14:7];
  endfunction

  // A zero magnitude always carries a positive sign so -0 never leaves the block.
  function automatic logic [7:0] f_pm_word(input logic sgn, input logic [6:0] mag,
                                           input logic [6:0] depth);
    logic [13:0] prod;
    prod = 14'(mag) * 14'(depth);
    return {sgn & (prod[13:7] != 7'd0), prod[13:7]};
  endfunction

  logic [19:0] r_acc;
  logic [7:0]  r_ph;
  logic        r_vld_p0;
  logic        r_tick_p0;
  logic [1:0]  r_w_p0;
  logic [6:0]  r_amd_p0;
  logic [6:0]  r_pmd_p0;
  logic [7:0]  r_pm_p1;
  logic [7:0]  r_am_p1;

  logic [19:0] w_mask;
  logic [20:0] w_sum;
  logic        w_carry;
  logic [7:0]  w_noise;
  logic [7:0]  w_am_raw;
  logic        w_sign;
  logic [6:0]  w_mag;

  // Only the low (20-e) accumulator bits are live; the carry out of that
  // field is the tick. Masking the stored value also drops stale high bits
  // left over when the exponent grows between frames.
  always_comb begin
    w_mask  = 20'hFFFFF >> lfrq[7:4];
    w_sum   = {1'b0, r_acc & w_mask} + {16'd0, 1'b1, lfrq[3:0]};
    w_carry = |(w_sum & {1'b1, ~w_mask});
  end

  // ---- stage A: frame cycle, accumulator / phase / LFSR ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_ph      <= '0;
      r_vld_p0  <= 1'b0;
      r_tick_p0 <= 1'b0;
    end else if (cen) begin
      r_vld_p0  <= zero;
      r_tick_p0 <= zero & ~lfo_rst & w_carry;
      if (zero) begin
        if (lfo_rst) begin
          r_acc <= '0;
          r_ph  <= '0;
        end else begin
          r_acc <= w_sum[19:0] & w_mask;
          if (w_carry) r_ph <= r_ph + 8'd1;
        end
      end
    end
  end

  // Waveform controls are captured with the frame so stage B sees a
  // consistent set even if the inputs move during the frame.
  always_ff @(posedge clk) begin
    if (cen && zero) begin
      r_w_p0   <= w;
      r_amd_p0 <= amd;
      r_pmd_p0 <= pmd;
    end
  end

`ifdef JT51_LFO_NOISE_EN
  logic [14:0] r_lfsr;

  // x^15 + x^14 + 1, shifting left; advances only on ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else if (cen && zero) begin
      if (lfo_rst)      r_lfsr <= SEED;
      else if (w_carry) r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
    end
  end

  assign w_noise = r_lfsr[7:0];
`else
  // No noise source in this build: the noise byte is zero, so w = 3 is
  // silent. SEED has no effect here and is masked off.
  assign w_noise = SEED[7:0] & 8'h00;
`endif

  always_comb begin
    w_am_raw = '0;
    w_sign   = 1'b0;
    w_mag    = '0;
    case (r_w_p0)
      2'd0: begin
        w_am_raw = ~r_ph;
        w_sign   = r_ph[7];
        w_mag    = r_ph[6:0];
      end
      2'd1: begin
        w_am_raw = r_ph[7] ? 8'd0 : 8'hFF;
        w_sign   = r_ph[7];
        w_mag    = 7'h7F;
      end
      2'd2: begin
        w_am_raw = r_ph[7] ? {r_ph[6:0], 1'b0} : {~r_ph[6:0], 1'b0};
        w_sign   = r_ph[7];
        w_mag    = {r_ph[6] ? ~r_ph[5:0] : r_ph[5:0], 1'b0};
      end
      default: begin
        w_am_raw = w_noise;
        w_sign   = w_noise[7];
        w_mag    = w_noise[6:0];
      end
    endcase
  end

  // ---- stage B: slot 1, waveform, depth scaling, output registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pm_p1 <= '0;
      r_am_p1 <= '0;
    end else if (cen && r_vld_p0) begin
      r_am_p1 <= f_am_scale(w_am_raw, r_amd_p0);
      r_pm_p1 <= f_pm_word(w_sign, w_mag, r_pmd_p0);
    end
  end

  assign pm       = r_pm_p1;
  assign am       = r_am_p1;
  assign lfo_tick = r_tick_p0;

endmodule

// File: tb/tb_jt51_lfo_pm.sv
module tb_jt51_lfo_pm;

  localparam logic [14:0] SEED = 15'h7FFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       zero = 1'b0;
  logic [7:0] lfrq = 8'h00;
  logic [1:0] w = 2'd0;
  logic [6:0] amd = 7'd0;
  logic [6:0] pmd = 7'd0;
  logic       lfo_rst = 1'b0;
  logic [7:0] pm;
  logic [7:0] am;
  logic       lfo_tick;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic       tick;
    logic [7:0] pm;
    logic [7:0] am;
    bit         chk_out;
    int         id;
  } exp_t;

  exp_t sb_q[$];

  int          ph_m = 0;
  logic [14:0] lfsr_m = SEED;
  int          frame_no = 0;

  jt51_lfo_pm #(.SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .lfrq(lfrq), .w(w),
    .amd(amd), .pmd(pmd), .lfo_rst(lfo_rst), .pm(pm), .am(am), .lfo_tick(lfo_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Output words from the waveform definitions, written with plain integer arithmetic.
  function automatic logic [15:0] f_exp(input int wv, input int ph, input int lf,
                                        input int ad, input int pd);
    int raw, sgn, mag, pmag, amv, pmv;
    raw = 0; sgn = 0; mag = 0;
    sgn = ph / 128;
    case (wv)
      0: begin raw = 255 - ph; mag = ph % 128; end
      1: begin raw = (ph >= 128) ? 0 : 255; mag = 127; end
      2: begin
        raw = (ph >= 128) ? (ph % 128) * 2 : (127 - ph % 128) * 2;
        mag = ((ph / 64) % 2 == 1) ? (63 - ph % 64) * 2 : (ph % 64) * 2;
      end
      default: begin
`ifdef JT51_LFO_NOISE_EN
        raw = lf % 256; sgn = (lf / 128) % 2; mag = lf % 128;
`else
        raw = 0; sgn = 0; mag = 0;
`endif
      end
    endcase
    amv  = (raw * ad) / 128;
    pmag = (mag * pd) / 128;
    pmv  = (pmag == 0) ? 0 : sgn * 128 + pmag;
    return {8'(pmv), 8'(amv)};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cen = 1'b1; zero = 1'b0; lfo_rst = 1'b0;
    end
  endtask

  task automatic do_frame(input int len, input bit tick, input bit rst_f,
                          input bit gap, input bit chk_out, input bit chk_hold);
    exp_t e;
    logic [15:0] o;
    if (rst_f) begin
      ph_m = 0; lfsr_m = SEED;
    end else if (tick) begin
      ph_m = (ph_m + 1) % 256;
      lfsr_m = {lfsr_m[13:0], lfsr_m[14] ^ lfsr_m[13]};
    end
    o = f_exp(int'(w), ph_m, int'(lfsr_m), int'(amd), int'(pmd));
    e.tick = tick & ~rst_f;
    e.pm = o[15:8];
    e.am = o[7:0];
    e.chk_out = chk_out;
    e.id = frame_no;
    frame_no++;
    sb_q.push_back(e);
    for (int s = 0; s < len; s++) begin
      @(negedge clk);
      if (chk_hold && s == 1) begin
        check($sformatf("f%0d_hold_pm", e.id), int'(pm), 0);
        check($sformatf("f%0d_hold_am", e.id), int'(am), 0);
      end
      cen = 1'b1;
      zero = (s == 0);
      lfo_rst = rst_f && (s == 0);
      if (gap) begin
        @(negedge clk);
        cen = 1'b0;
      end
    end
  endtask

  // Monitor: a frame edge is cen & zero; the tick pulse is visible right
  // after it, the output words after the next enabled edge.
  initial begin : monitor
    exp_t e;
    logic tk;
    int   waitc;
    forever begin
      @(posedge clk);
      if (rst_n && cen && zero) begin
        @(negedge clk);
        tk = lfo_tick;
        waitc = 0;
        do begin
          @(posedge clk);
          waitc++;
        end while (!cen && waitc < 64);
        @(negedge clk);
        if (waitc >= 64) begin
          n_chk++; n_err++;
          $display("FAIL stageB_timeout: got no enabled edge, expected one within 64 cycles");
        end else if (sb_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL scoreboard: got an output frame, expected none");
        end else begin
          e = sb_q.pop_front();
          check($sformatf("f%0d_tick", e.id), int'(tk), int'(e.tick));
          check($sformatf("f%0d_tick_clr", e.id), int'(lfo_tick), 0);
          if (e.chk_out) begin
            check($sformatf("f%0d_pm", e.id), int'(pm), int'(e.pm));
            check($sformatf("f%0d_am", e.id), int'(am), int'(e.am));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pm", int'(pm), 0);
    check("rst_am", int'(am), 0);
    check("rst_tick", int'(lfo_tick), 0);

    // Release; nothing may change before the first frame's slot 1
    lfrq = 8'h00; w = 2'd1; amd = 7'd127; pmd = 7'd127;
    @(negedge clk); rst_n = 1'b1;
    idle(3);
    check("post_rst_pm", int'(pm), 0);
    do_frame(32, 0, 0, 0, 1, 1);
    check("sq_ph0_pm", int'(pm), 8'h7E);
    check("sq_ph0_am", int'(am), 253);

    // Rate e=15 m=0: tick every second frame, ph = 8 after 16 frames
    lfrq = 8'hF0; w = 2'd0;
    do_frame(32, 0, 1, 0, 1, 0);
    for (int i = 1; i <= 16; i++) do_frame(32, (i % 2) == 0, 0, i == 5, 1, 0);
    check("saw_ph8_pm", int'(pm), 7);
    check("saw_ph8_am", int'(am), 245);

    // Rate e=15 m=15: 31 ticks per 32 frames from a cleared accumulator
    lfrq = 8'hFF; w = 2'd1;
    do_frame(8, 0, 1, 0, 1, 0);
    k = 0;
    for (int i = 1; i <= 32; i++) begin
      k++;
      do_frame(8, (k % 32) != 1, 0, 0, 1, 0);
    end
    check("sq_ph31_pm", int'(pm), 8'h7E);
    check("sq_ph31_am", int'(am), 253);
    while (ph_m < 128) begin
      k++;
      do_frame(8, (k % 32) != 1, 0, 0, 1, 0);
    end
    check("sq_ph128_pm", int'(pm), 8'hFE);
    check("sq_ph128_am", int'(am), 0);
    while (ph_m < 144) begin
      k++;
      do_frame(8, (k % 32) != 1, 0, 0, 1, 0);
    end

    // Hold ph = 0x90 with a very slow rate and look at saw / triangle
    lfrq = 8'h00; w = 2'd0; amd = 7'd0; pmd = 7'd64;
    do_frame(8, 0, 0, 0, 1, 0);
    check("saw_90_pm", int'(pm), 8'h88);
    check("saw_90_am", int'(am), 0);
    pmd = 7'd0;
    do_frame(8, 0, 0, 0, 1, 0);
    check("saw_pmd0_pm", int'(pm), 8'h00);
    w = 2'd2; amd = 7'd127; pmd = 7'd127;
    do_frame(8, 0, 0, 1, 1, 0);
    check("tri_90_pm", int'(pm), 8'h9F);
    check("tri_90_am", int'(am), 31);

    // Noise: restart loads SEED, first tick gives 7FFE
    lfrq = 8'hF0; w = 2'd3;
    do_frame(8, 0, 1, 0, 1, 0);
    do_frame(8, 0, 0, 0, 1, 0);
`ifdef JT51_LFO_NOISE_EN
    check("noise_seed_pm", int'(pm), 8'hFE);
    check("noise_seed_am", int'(am), 253);
`else
    check("noise_off_pm", int'(pm), 0);
    check("noise_off_am", int'(am), 0);
`endif
    do_frame(8, 1, 0, 0, 1, 0);
`ifdef JT51_LFO_NOISE_EN
    check("noise_t1_pm", int'(pm), 8'hFD);
    check("noise_t1_am", int'(am), 252);
`else
    check("noise_off_t1_pm", int'(pm), 0);
    check("noise_off_t1_am", int'(am), 0);
`endif

    // 40 ticks then restart on a frame that would also tick
    lfrq = 8'hFF; w = 2'd0; amd = 7'd100; pmd = 7'd127;
    do_frame(8, 0, 1, 0, 1, 0);
    for (int i = 1; i <= 42; i++) do_frame(8, (i % 32) != 1, 0, 0, 1, 0);
    check("saw_ph40_pm", int'(pm), 39);
    check("saw_ph40_am", int'(am), 167);
    do_frame(8, 1, 1, 0, 1, 0);
    check("lforst_pm", int'(pm), 0);
    check("lforst_am", int'(am), 199);

    // Reset in the middle of a frame
    lfrq = 8'h00; w = 2'd1; amd = 7'd127; pmd = 7'd127;
    do_frame(17, 0, 0, 0, 1, 0);
    @(negedge clk);
    cen = 1'b1; zero = 1'b0; lfo_rst = 1'b0; rst_n = 1'b0;
    #1;
    check("midrst_pm", int'(pm), 0);
    check("midrst_am", int'(am), 0);
    check("midrst_tick", int'(lfo_tick), 0);
    @(negedge clk); rst_n = 1'b1;
    ph_m = 0; lfsr_m = SEED;
    idle(13);
    check("midrst_hold_pm", int'(pm), 0);
    check("midrst_hold_am", int'(am), 0);
    do_frame(32, 0, 0, 0, 1, 1);
    check("midrst_after_pm", int'(pm), 8'h7E);
    check("midrst_after_am", int'(am), 253);

    idle(4);
    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/jt51_lfo_pm.md
# jt51_lfo_pm

Low-frequency oscillator for JT51. It produces the sign-magnitude phase-modulation word `pm` consumed by the phase generator, and the unsigned amplitude-modulation word `am` consumed by the envelope stage. It runs once per 32-slot sample frame, marked by `zero`. It holds both outputs constant across all 32 slots of a frame.

## Interface
Parameters:
- `SEED`, 15'h7FFF — noise LFSR load value on reset and on `lfo_rst`; must be nonzero.

Ports:
- `clk`  in  1  system clock; one clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cen`  in  1  clock enable; no state changes when low.
- `zero`  in  1  high for one `cen` cycle at slot 0 of each frame.
- `lfrq`  in  8  rate; `[7:4]` = exponent e, `[3:0]` = mantissa m.
- `w`  in  2  waveform: 0 saw, 1 square, 2 triangle, 3 noise.
- `amd`  in  7  AM depth, 0..127.
- `pmd`  in  7  PM depth, 0..127.
- `lfo_rst`  in  1  synchronous LFO restart (level).
- `pm`  out  8  bit 7 = sign (1 = subtract), `[6:0]` = magnitude.
- `am`  out  8  unsigned AM attenuation.
- `lfo_tick`  out  1  one-`cen` pulse when the LFO phase advances.

## Operation
- **Rate accumulator.** `acc` is 20 bits. On each cycle with `cen & zero`, it adds `{1'b1, m}` (16..31).
  - A tick occurs when that addition carries out of bit (19−e), i.e. out of the low (20−e) bits.
  - Bits above (19−e) are held at 0.
  - Tick rate is (16+m)/2^(20−e) per frame.
- **Tick effects.** On a tick:
  - 8-bit phase `ph` increments and wraps 255→0.
  - The LFSR advances: 15-bit Fibonacci, taps x^15+x^14+1, shifting left, feedback = bit14 ^ bit13.
  - `lfo_tick` pulses.
- **Raw waveforms** (from the `ph` and LFSR values after the tick):
  - Saw (0): am_raw = ~ph; sign = ph[7]; mag = ph[6:0].
  - Square (1): am_raw = ph[7] ? 0 : 255; sign = ph[7]; mag = 127.
  - Triangle (2): am_raw = ph[7] ? {ph[6:0],0} : {~ph[6:0],0}; sign = ph[7]; mag = {ph[6] ? ~ph[5:0] : ph[5:0], 0}.
  - Noise (3): am_raw = lfsr[7:0]; sign = lfsr[7]; mag = lfsr[6:0].
- **Depth scaling:**
  - am = (am_raw × amd)[14:7].
  - pmag = (mag × pmd)[13:7].
  - pm = {pmag==0 ? 0 : sign, pmag}. Negative zero is never emitted.
- **Input sampling.** `lfrq`, `w`, `amd`, `pmd` are sampled only on `cen & zero` cycles. Changing `lfrq` mid-frame has no effect until the next `zero`.
- **`lfo_rst`.** While high on a `cen & zero` cycle:
  - `acc`, `ph` ← 0; LFSR ← `SEED`; no tick.
  - Outputs then update from ph = 0 / `SEED`.
- **Depth 0.** amd = 0 → am = 0; pmd = 0 → pm = 0, independent of waveform.

## Timing
- **Reset values.** While `rst_n` low, the outputs clear immediately (asynchronously): `pm` = 0, `am` = 0, `lfo_tick` = 0. Internal state: `acc` = 0, `ph` = 0, LFSR = `SEED`.
- **Two-stage pipeline, both gated by `cen`:**
  - Stage A, on the `cen & zero` cycle: `acc`/`ph`/LFSR update; `lfo_tick` asserted on the following `cen` cycle.
  - Stage B, on the next `cen` cycle (slot 1): waveform, multiply and output registers update. `pm`/`am` change only here.
- **Steady state.** Outputs are stable from slot 1 of frame N through slot 0 of frame N+1.
- **After reset.** The first output update is at slot 1 of the first frame after `rst_n` deasserts.
- **`cen` low.** Every stage holds, including between stage A and stage B.
- **Simultaneous tick and `lfo_rst`:** `lfo_rst` wins; no tick pulse.
- **`zero` asserted on consecutive `cen` cycles:** each is treated as a frame; no error state.

## Configuration
- `JT51_LFO_NOISE_EN` defined: LFSR instantiated; w = 3 selects noise.
- Not defined: no LFSR logic. w = 3 forces am_raw = 0 and mag = 0, so pm = 0 and am = 0. `SEED` is ignored.

## Test plan
1. **Tick rate.** lfrq = 8'hF0, `zero` every 32 `cen` → `lfo_tick` every 2nd frame; `ph` = 8 after 16 frames. lfrq = 8'hFF → 31 ticks per 32 frames.
2. **Square wave.** w = 1, pmd = 127, amd = 127 at ph = 0 → pm = 8'h7E (126), am = 253. After 128 ticks → pm = 8'hFE, am = 0.
3. **Saw wave.** w = 0, pmd = 64, amd = 0, ph = 8'h90 → pm = {1, 8}; am = 0. With pmd = 0 → pm = 8'h00; sign suppressed.
4. **Noise** (macro on). w = 3, pmd = 127 → first tick after reset gives LFSR = 15'h7FFE, and pm follows lfsr[7:0] per the formula. With the macro off → pm = 0, am = 0.
5. **LFO restart.** Run 40 ticks, assert `lfo_rst` on a zero cycle → slot 1: `ph` = 0, saw am = (255×amd)>>7, no `lfo_tick`.
6. **Reset mid-frame.** `rst_n` low at slot 17 → `pm`/`am` = 0 within the same cycle. Release → outputs stay 0 until slot 1 of the next frame.
